// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU among NUM_REQ
// requesters and returns each result with its requester id over a valid/ready channel.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ*32-1:0]   i_req_op_a,
    input  logic [NUM_REQ*32-1:0]   i_req_op_b,
    input  logic [NUM_REQ*4-1:0]    i_req_alu_op,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic [31:0]             o_alu_op_a,
    output logic [31:0]             o_alu_op_b,
    output logic [3:0]              o_alu_op,
    input  logic [31:0]             i_alu_data,
    output logic                    o_rsp_valid,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [31:0]             o_rsp_data,
    input  logic                    i_rsp_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     lat_id;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     next_ptr;
    logic                grant_found;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [31:0]         sel_a;
    logic [31:0]         sel_b;
    logic [3:0]          sel_op;
    logic                can_accept;
    logic                accept;

    // Winner is the valid requester with the smallest rotational distance from rr_ptr.
    always_comb begin
        int best_d;
        int d;
        best_d   = NUM_REQ;
        d        = 0;
        grant_id = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            d = (j - int'(rr_ptr) + NUM_REQ) % NUM_REQ;
            if (i_req_valid[j] && d < best_d) begin
                best_d   = d;
                grant_id = ID_W'(j);
            end
        end
        grant_found = |i_req_valid;
    end

    always_comb begin
        grant_onehot = '0;
        sel_a        = '0;
        sel_b        = '0;
        sel_op       = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant_onehot[j] = grant_found && (grant_id == ID_W'(j));
            if (grant_onehot[j]) begin
                sel_a  = i_req_op_a[j*32 +: 32];
                sel_b  = i_req_op_b[j*32 +: 32];
                sel_op = i_req_alu_op[j*4 +: 4];
            end
        end
    end

    always_comb begin
        next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        can_accept  = !i_rst && ((state == IDLE) || (state == RESP && i_rsp_ready));
        accept      = can_accept && grant_found;
        o_req_ready = accept ? grant_onehot : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            lat_id      <= '0;
            o_alu_op_a  <= '0;
            o_alu_op_b  <= '0;
            o_alu_op    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_data  <= '0;
        end else begin
            if (accept) begin
                o_alu_op_a <= sel_a;
                o_alu_op_b <= sel_b;
                o_alu_op   <= sel_op;
                lat_id     <= grant_id;
                rr_ptr     <= next_ptr;
            end
            case (state)
                IDLE: begin
                    if (accept) state <= EXEC;
                end
                EXEC: begin
                    o_rsp_data  <= i_alu_data;
                    o_rsp_id    <= lat_id;
                    o_rsp_valid <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    // Response data stays put while the consumer stalls.
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= accept ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
